// File: rtl/ir_pkg.sv
// Shared types and field positions for the NEC IR key decoder.
// Frame layout, event bundle and FSM encoding.
package ir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam int ADDR_LSB  = 0;
  localparam int IADDR_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int ICMD_LSB  = 24;

  localparam int EVT_W = 17;

  typedef struct packed {
    logic       rep;
    logic [7:0] addr;
    logic [7:0] cmd;
  } key_evt_t;

endpackage

// File: rtl/ir_event_fifo.sv
// First-word-fall-through event FIFO.
// Head reads as zero while empty.
module ir_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Full is judged before any same-cycle pop.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ir_key_decoder.sv
// Turns NEC receiver frames into validated key events
// (press/repeat) queued behind a valid/ready handshake.
module ir_key_decoder
  import ir_pkg::*;
#(
  parameter int unsigned REPEAT_WINDOW = 6_000_000,
  parameter logic [7:0]  ADDRESS       = 8'h00,
  parameter bit          CHECK_ADDR    = 1'b1,
  parameter int          DEPTH         = 4
) (
  input  logic        i_CLOCK_POS,
  input  logic        i_RESET_NEG,
  input  logic        i_DATA_READY,
  input  logic [31:0] i_DATA,
  output logic        o_KEY_VALID,
  input  logic        i_KEY_READY,
  output logic [7:0]  o_KEY_ADDR,
  output logic [7:0]  o_KEY_CMD,
  output logic        o_KEY_REPEAT,
  output logic [7:0]  o_DROP_COUNT,
  output logic        o_OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [23:0] WIN = 24'(REPEAT_WINDOW);

  state_e      state_q, state_d;
  logic        rdy1_q, rdy1_d;
  logic        rdy2_q, rdy2_d;
  logic [31:0] frame_q, frame_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic        last_vld_q, last_vld_d;
  logic [23:0] gap_q, gap_d;
  logic [7:0]  drop_q, drop_d;
  logic        ovf_q, ovf_d;

  logic        new_frame, frame_ok, push;
  logic [7:0]  f_addr, f_iaddr, f_cmd, f_icmd;
  key_evt_t    evt, head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count_unused;

  assign f_addr  = frame_q[ADDR_LSB  +: 8];
  assign f_iaddr = frame_q[IADDR_LSB +: 8];
  assign f_cmd   = frame_q[CMD_LSB   +: 8];
  assign f_icmd  = frame_q[ICMD_LSB  +: 8];

  always_comb begin
    rdy1_d     = i_DATA_READY;
    rdy2_d     = rdy1_q;
    new_frame  = rdy1_q & ~rdy2_q;
    frame_ok   = (f_addr == ~f_iaddr)
               && (f_cmd == ~f_icmd)
               && (!CHECK_ADDR || f_addr == ADDRESS);
    state_d    = state_q;
    frame_d    = frame_q;
    last_cmd_d = last_cmd_q;
    last_vld_d = last_vld_q;
    gap_d      = (gap_q >= WIN) ? WIN : gap_q + 24'd1;
    drop_d     = drop_q;
    push       = 1'b0;
    evt        = '0;
    unique case (state_q)
      IDLE: begin
        if (new_frame) begin
          frame_d = i_DATA;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) begin
          evt.rep    = last_vld_q
                     && (f_cmd == last_cmd_q)
                     && (gap_q < WIN);
          evt.addr   = f_addr;
          evt.cmd    = f_cmd;
          push       = 1'b1;
          last_cmd_d = f_cmd;
          last_vld_d = 1'b1;
          gap_d      = '0;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_q | (push & fifo_full);
  end

  // Ready regs reset high so a level held across reset is not an edge.
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      state_q    <= IDLE;
      rdy1_q     <= 1'b1;
      rdy2_q     <= 1'b1;
      frame_q    <= '0;
      last_cmd_q <= '0;
      last_vld_q <= 1'b0;
      gap_q      <= WIN;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      frame_q    <= frame_d;
      last_cmd_q <= last_cmd_d;
      last_vld_q <= last_vld_d;
      gap_q      <= gap_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  ir_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (i_CLOCK_POS),
    .rst_n (i_RESET_NEG),
    .push  (push),
    .wdata (evt),
    .pop   (o_KEY_VALID & i_KEY_READY),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign o_KEY_VALID  = ~fifo_empty;
  assign o_KEY_ADDR   = head.addr;
  assign o_KEY_CMD    = head.cmd;
  assign o_KEY_REPEAT = head.rep;
  assign o_DROP_COUNT = drop_q;
  assign o_OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_ir_key_decoder.sv
// Directed bench for ir_key_decoder: two instances,
// address filter on (dut) and off (dut2).
module tb_ir_key_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        kr;
  logic [31:0] data;

  logic       v1, rp1, ov1;
  logic [7:0] a1, c1, d1;
  logic       v2, rp2, ov2;
  logic [7:0] a2, c2, d2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ir_key_decoder #(
    .REPEAT_WINDOW (1000),
    .ADDRESS       (8'h00),
    .CHECK_ADDR    (1'b1),
    .DEPTH         (4)
  ) dut (
    .i_CLOCK_POS  (clk),
    .i_RESET_NEG  (rst_n),
    .i_DATA_READY (rdy),
    .i_DATA       (data),
    .o_KEY_VALID  (v1),
    .i_KEY_READY  (kr),
    .o_KEY_ADDR   (a1),
    .o_KEY_CMD    (c1),
    .o_KEY_REPEAT (rp1),
    .o_DROP_COUNT (d1),
    .o_OVERFLOW   (ov1)
  );

  ir_key_decoder #(
    .REPEAT_WINDOW (1000),
    .ADDRESS       (8'h00),
    .CHECK_ADDR    (1'b0),
    .DEPTH         (4)
  ) dut2 (
    .i_CLOCK_POS  (clk),
    .i_RESET_NEG  (rst_n),
    .i_DATA_READY (rdy),
    .i_DATA       (data),
    .o_KEY_VALID  (v2),
    .i_KEY_READY  (1'b1),
    .o_KEY_ADDR   (a2),
    .o_KEY_CMD    (c2),
    .o_KEY_REPEAT (rp2),
    .o_DROP_COUNT (d2),
    .o_OVERFLOW   (ov2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nec(input logic [7:0] a,
                                      input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic pulse(input logic [31:0] d);
    data = d;
    rdy  = 1'b1;
    tick(5);
    rdy  = 1'b0;
    tick(5);
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b0;
    kr    = 1'b0;
    data  = '0;
    tick(3);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_addr", {24'd0, a1}, 32'd0);
    chk("rst_cmd", {24'd0, c1}, 32'd0);
    chk("rst_rep", {31'd0, rp1}, 32'd0);
    chk("rst_drop", {24'd0, d1}, 32'd0);
    chk("rst_ovf", {31'd0, ov1}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // first press, latency 3
    data = 32'hBA45FF00;
    rdy  = 1'b1;
    tick(2);
    chk("lat_n2_valid", {31'd0, v1}, 32'd0);
    tick(1);
    chk("lat_n3_valid", {31'd0, v1}, 32'd1);
    chk("p1_addr", {24'd0, a1}, 32'h00);
    chk("p1_cmd", {24'd0, c1}, 32'h45);
    chk("p1_rep", {31'd0, rp1}, 32'd0);
    chk("p1_dut2_valid", {31'd0, v2}, 32'd1);
    kr = 1'b1;
    tick(1);
    chk("p1_popped", {31'd0, v1}, 32'd0);
    tick(45);
    rdy = 1'b0;
    chk("p1_single", {31'd0, v1}, 32'd0);
    tick(5);

    // repeat inside window
    tick(400);
    rdy = 1'b1;
    tick(3);
    chk("rep_valid", {31'd0, v1}, 32'd1);
    chk("rep_flag", {31'd0, rp1}, 32'd1);
    tick(10);
    rdy = 1'b0;
    tick(5);

    // same cmd after window expired
    tick(2000);
    rdy = 1'b1;
    tick(3);
    chk("late_valid", {31'd0, v1}, 32'd1);
    chk("late_rep", {31'd0, rp1}, 32'd0);
    tick(5);
    rdy = 1'b0;
    tick(5);

    // bad address complement
    data = 32'hBA45FE00;
    rdy  = 1'b1;
    tick(3);
    chk("badc_valid", {31'd0, v1}, 32'd0);
    chk("badc_drop", {24'd0, d1}, 32'd1);
    chk("badc_drop2", {24'd0, d2}, 32'd1);
    rdy = 1'b0;
    tick(5);

    // wrong address: filtered vs accepted
    data = 32'hBA45FE01;
    rdy  = 1'b1;
    tick(3);
    chk("filt_valid", {31'd0, v1}, 32'd0);
    chk("filt_drop", {24'd0, d1}, 32'd2);
    chk("nofilt_valid", {31'd0, v2}, 32'd1);
    chk("nofilt_addr", {24'd0, a2}, 32'h01);
    chk("nofilt_cmd", {24'd0, c2}, 32'h45);
    chk("nofilt_drop", {24'd0, d2}, 32'd1);
    rdy = 1'b0;
    tick(5);

    // overflow with consumer stalled
    kr = 1'b0;
    for (int c = 1; c <= 5; c++) pulse(nec(8'h00, 8'(c)));
    chk("ovf_flag", {31'd0, ov1}, 32'd1);
    chk("ovf_valid", {31'd0, v1}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_cmd", {24'd0, c1}, 32'(i));
      chk("drain_rep", {31'd0, rp1}, 32'd0);
      kr = 1'b1;
      tick(1);
    end
    chk("drain_empty", {31'd0, v1}, 32'd0);
    chk("ovf_sticky", {31'd0, ov1}, 32'd1);

    // async reset with queued entries
    kr = 1'b0;
    pulse(nec(8'h00, 8'h10));
    pulse(nec(8'h00, 8'h11));
    chk("pre_rst_valid", {31'd0, v1}, 32'd1);
    data = nec(8'h00, 8'h10);
    rdy  = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, v1}, 32'd0);
    chk("arst_addr", {24'd0, a1}, 32'd0);
    chk("arst_cmd", {24'd0, c1}, 32'd0);
    chk("arst_rep", {31'd0, rp1}, 32'd0);
    chk("arst_drop", {24'd0, d1}, 32'd0);
    chk("arst_ovf", {31'd0, ov1}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("held_rdy_noevt", {31'd0, v1}, 32'd0);
    rdy = 1'b0;
    tick(5);
    data = nec(8'h00, 8'h11);
    rdy  = 1'b1;
    tick(3);
    chk("post_rst_valid", {31'd0, v1}, 32'd1);
    chk("post_rst_cmd", {24'd0, c1}, 32'h11);
    chk("post_rst_rep", {31'd0, rp1}, 32'd0);
    rdy = 1'b0;
    tick(5);

    // drop counter saturation
    data = 32'hBA45FE00;
    for (int i = 0; i < 260; i++) begin
      rdy = 1'b1;
      tick(3);
      rdy = 1'b0;
      tick(3);
    end
    chk("sat_drop", {24'd0, d1}, 32'd255);
    chk("sat_drop2", {24'd0, d2}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
